// File: rtl/updown_mod_counter.sv
// Synchronous up/down counter with programmable modulus, parallel load,
// count enable and a registered terminal-count pulse. Everything runs on
// the rising edge of clk; nothing in here derives a clock.
module updown_mod_counter #(
    parameter int WIDTH     = 4,
    parameter int MAX_COUNT = (1 << WIDTH) - 1,
    parameter bit SATURATE  = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             at_max,
    output logic             at_zero
);

    // A terminal value that does not fit in WIDTH bits would silently
    // truncate, so refuse to elaborate instead.
    if (WIDTH < 1) begin : g_bad_width
        $error("updown_mod_counter: WIDTH must be >= 1");
    end
    if (MAX_COUNT < 0 || MAX_COUNT > (1 << WIDTH) - 1) begin : g_bad_max
        $error("updown_mod_counter: MAX_COUNT must lie in 0..2**WIDTH-1");
    end

    localparam logic [WIDTH-1:0] MAX_V = MAX_COUNT[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ZERO_V = '0;

    logic [WIDTH-1:0] r_count;
    logic             r_tc;

    logic             w_at_max;
    logic             w_at_zero;
    logic             w_at_bound;
    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] w_load_clamped;

    assign w_at_max  = (r_count == MAX_V);
    assign w_at_zero = (r_count == ZERO_V);

    // Boundary for the requested direction: an enabled step from here wraps
    // (or holds when saturating) and raises tc on the same edge.
    assign w_at_bound = up_dn ? w_at_max : w_at_zero;

    // Loads above the terminal value are clamped so the count never leaves
    // the 0..MAX_COUNT range.
    assign w_load_clamped = (load_val > MAX_V) ? MAX_V : load_val;

    // Next count for an enabled step, wrapping modulo MAX_COUNT+1 or holding.
    always_comb begin
        w_step = r_count;
        if (up_dn) begin
            if (w_at_max) begin
                w_step = SATURATE ? MAX_V : ZERO_V;
            end else begin
                w_step = r_count + 1'b1;
            end
        end else begin
            if (w_at_zero) begin
                w_step = SATURATE ? ZERO_V : MAX_V;
            end else begin
                w_step = r_count - 1'b1;
            end
        end
    end

    // Count and tc registers; priority is reset, then load, then enable.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count <= '0;
            r_tc    <= 1'b0;
        end else if (load) begin
            r_count <= w_load_clamped;
            r_tc    <= 1'b0;
        end else if (en) begin
            r_count <= w_step;
            r_tc    <= w_at_bound;
        end else begin
            r_tc    <= 1'b0;
        end
    end

    assign count   = r_count;
    assign tc      = r_tc;
    assign at_max  = w_at_max;
    assign at_zero = w_at_zero;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Bench for updown_mod_counter: two instances share one stimulus stream,
// a wrapping decade counter (MAX_COUNT=9) and a saturating 4-bit counter
// (MAX_COUNT=15). An arithmetic model is compared every cycle and directed
// steps carry hand-computed literal expectations.
module tb_updown_mod_counter;

    localparam int W     = 4;
    localparam int MAX_A = 9;
    localparam int MAX_B = 15;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         en = 1'b0;
    logic         up_dn = 1'b1;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;

    logic [W-1:0] count_a, count_b;
    logic         tc_a, tc_b, at_max_a, at_max_b, at_zero_a, at_zero_b;

    int checks = 0;
    int errors = 0;

    updown_mod_counter #(.WIDTH(W), .MAX_COUNT(MAX_A), .SATURATE(1'b0)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .count(count_a), .tc(tc_a), .at_max(at_max_a),
        .at_zero(at_zero_a)
    );

    updown_mod_counter #(.WIDTH(W), .MAX_COUNT(MAX_B), .SATURATE(1'b1)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .count(count_b), .tc(tc_b), .at_max(at_max_b),
        .at_zero(at_zero_b)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int ma_cnt = 0, mb_cnt = 0;
    bit ma_tc = 0, mb_tc = 0;
    bit model_valid = 0;

    function automatic int next_cnt(input int c, input int maxc, input bit sat,
                                    input bit up);
        int m;
        m = maxc + 1;
        if (sat) begin
            if (up)  return (c == maxc) ? maxc : c + 1;
            else     return (c == 0) ? 0 : c - 1;
        end
        if (up) return (c + 1) % m;
        return (c + maxc) % m;
    endfunction

    function automatic int clamp(input int v, input int maxc);
        return (v > maxc) ? maxc : v;
    endfunction

    always @(posedge clk) begin
        if (!reset_n) begin
            ma_cnt = 0; mb_cnt = 0; ma_tc = 0; mb_tc = 0;
            model_valid = 1;
        end else if (load) begin
            ma_cnt = clamp(int'(load_val), MAX_A);
            mb_cnt = clamp(int'(load_val), MAX_B);
            ma_tc = 0; mb_tc = 0;
        end else if (en) begin
            ma_tc = up_dn ? (ma_cnt == MAX_A) : (ma_cnt == 0);
            mb_tc = up_dn ? (mb_cnt == MAX_B) : (mb_cnt == 0);
            ma_cnt = next_cnt(ma_cnt, MAX_A, 1'b0, up_dn);
            mb_cnt = next_cnt(mb_cnt, MAX_B, 1'b1, up_dn);
        end else begin
            ma_tc = 0; mb_tc = 0;
        end
    end

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (model_valid) begin
            cmp("a.count", int'(count_a), ma_cnt);
            cmp("a.tc", int'(tc_a), int'(ma_tc));
            cmp("a.at_max", int'(at_max_a), int'(ma_cnt == MAX_A));
            cmp("a.at_zero", int'(at_zero_a), int'(ma_cnt == 0));
            cmp("b.count", int'(count_b), mb_cnt);
            cmp("b.tc", int'(tc_b), int'(mb_tc));
            cmp("b.at_max", int'(at_max_b), int'(mb_cnt == MAX_B));
            cmp("b.at_zero", int'(at_zero_b), int'(mb_cnt == 0));
        end
    end

    // One clock with the given inputs; returns shortly after the edge.
    task automatic step(input bit rn, input bit e, input bit u, input bit ld,
                        input int lv);
        reset_n  = rn;
        en       = e;
        up_dn    = u;
        load     = ld;
        load_val = lv[W-1:0];
        @(posedge clk);
        #2;
    endtask

    // Literal expectation checked against both the DUT and the model.
    task automatic lit_a(input string name, input int cnt, input int t);
        cmp({name, ".a.count"}, int'(count_a), cnt);
        cmp({name, ".a.tc"}, int'(tc_a), t);
        cmp({name, ".model_a.count"}, ma_cnt, cnt);
    endtask

    task automatic lit_b(input string name, input int cnt, input int t);
        cmp({name, ".b.count"}, int'(count_b), cnt);
        cmp({name, ".b.tc"}, int'(tc_b), t);
        cmp({name, ".model_b.count"}, mb_cnt, cnt);
    endtask

    int up_exp_cnt[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    int dn_exp_cnt[3]  = '{9, 8, 7};
    int dn_exp_tc[3]   = '{1, 0, 0};
    int sat_exp_tc[3]  = '{0, 1, 1};

    initial begin
        #1;
        // 1: reset dominates load and en
        step(0, 1, 1, 1, 5);
        step(0, 1, 1, 1, 5);
        lit_a("reset", 0, 0);
        lit_b("reset", 0, 0);
        cmp("reset.a.at_zero", int'(at_zero_a), 1);
        cmp("reset.a.at_max", int'(at_max_a), 0);

        // 2: up count through the decade wrap
        for (int i = 0; i < 12; i++) begin
            step(1, 1, 1, 0, 0);
            lit_a("upwrap", up_exp_cnt[i], (up_exp_cnt[i] == 0 && i == 9) ? 1 : 0);
            lit_b("upsat", i + 1, 0);
        end

        // 3: load 0, then count down through the wrap
        step(1, 1, 1, 1, 0);
        lit_a("load0", 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 0, 0);
            lit_a("dnwrap", dn_exp_cnt[i], dn_exp_tc[i]);
            lit_b("dnsat", 0, 1);
        end

        // 4: saturate at the top; A clamps the same load to 9 and wraps
        step(1, 0, 1, 1, 14);
        lit_b("load14", 14, 0);
        lit_a("clamp14", 9, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 1, 0, 0);
            lit_b("satup", 15, sat_exp_tc[i]);
            cmp("satup.b.at_max", int'(at_max_b), 1);
            lit_a("wrap_after_clamp", i, (i == 0) ? 1 : 0);
        end

        // 5: load beats en and clamps; next enabled step wraps with tc
        step(1, 1, 1, 1, 12);
        lit_a("ldclamp", 9, 0);
        cmp("ldclamp.a.at_max", int'(at_max_a), 1);
        lit_b("ld12", 12, 0);
        step(1, 1, 1, 0, 0);
        lit_a("ldwrap", 0, 1);

        // 6: reset mid-count with en high, then resume and hold
        step(1, 0, 1, 1, 5);
        lit_a("ld5", 5, 0);
        step(0, 1, 1, 0, 0);
        lit_a("midreset", 0, 0);
        for (int i = 1; i <= 3; i++) begin
            step(1, 1, 1, 0, 0);
            lit_a("resume", i, 0);
        end
        step(1, 0, 0, 0, 0);
        lit_a("hold", 3, 0);
        step(1, 0, 1, 0, 0);
        lit_a("hold2", 3, 0);

        // boundary: en=0 with count at top of A does not raise tc
        step(1, 0, 1, 1, 9);
        step(1, 0, 1, 0, 0);
        lit_a("idle_at_max", 9, 0);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
